// File: rtl/acc_pkg.sv
// Shared types and default sizing for the accumulator bank and its save stack.
package acc_pkg;

  localparam int ACC_DATA_W      = 8;
  localparam int ACC_NUM_ACC     = 4;
  localparam int ACC_STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    ACC_SRC_ALU = 2'd0,
    ACC_SRC_MEM = 2'd1,
    ACC_SRC_IMM = 2'd2,
    ACC_SRC_CLR = 2'd3
  } acc_src_e;

endpackage

// File: rtl/acc_bank_if.sv
// Control-unit side bundle of the accumulator bank: write/read selects, data buses, stack ops, flags.
interface acc_bank_if
  import acc_pkg::*;
#(
  parameter int DATA_W  = ACC_DATA_W,
  parameter int NUM_ACC = ACC_NUM_ACC
);

  localparam int AW = $clog2(NUM_ACC);

  logic              wr_en;
  logic [AW-1:0]     wr_sel;
  acc_src_e          src_sel;
  logic [DATA_W-1:0] data_alu;
  logic [DATA_W-1:0] data_mem;
  logic [DATA_W-1:0] data_imm;
  logic [AW-1:0]     rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic              flag_z;
  logic              flag_n;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output wr_en, wr_sel, src_sel, data_alu, data_mem, data_imm,
    output rd_sel, push, pop, err_clr,
    input  rd_data, flag_z, flag_n, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  wr_en, wr_sel, src_sel, data_alu, data_mem, data_imm,
    input  rd_sel, push, pop, err_clr,
    output rd_data, flag_z, flag_n, stack_full, stack_empty, stack_err
  );

endinterface

// File: rtl/acc_stack.sv
// LIFO save stack for accumulator context; rejects overflow, underflow and simultaneous push/pop.
module acc_stack #(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              err_pulse
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SPW-1:0] DEPTH_V = SPW'(STACK_DEPTH);

  logic [DATA_W-1:0] mem [1 << IW];
  logic [SPW-1:0]    sp;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     wr_idx;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (sp == DEPTH_V);
  assign empty     = (sp == '0);
  assign push_ok   = push & ~pop & ~full;
  assign pop_ok    = pop & ~push & ~empty;
  assign err_pulse = (push & pop) | (push & full) | (pop & empty);

  assign top_idx = IW'(sp - SPW'(1));
  assign wr_idx  = IW'(sp);
  assign dout    = mem[top_idx];

  // The pointer saturates by refusing illegal ops rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push_ok) begin
      sp <= sp + SPW'(1);
    end else if (pop_ok) begin
      sp <= sp - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/acc_bank.sv
// Accumulator bank: source mux, register array, zero/negative flags, save stack and sticky stack error.
module acc_bank
  import acc_pkg::*;
#(
  parameter int DATA_W      = ACC_DATA_W,
  parameter int NUM_ACC     = ACC_NUM_ACC,
  parameter int STACK_DEPTH = ACC_STACK_DEPTH
) (
  input logic       clk,
  input logic       rst,
  acc_bank_if.slave bus
);

  localparam int AW = $clog2(NUM_ACC);
  localparam logic [AW:0] NUM_ACC_V = (AW + 1)'(NUM_ACC);

  logic [DATA_W-1:0] acc [NUM_ACC];
  logic [DATA_W-1:0] src_data;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] stk_dout;
  logic              wr_ok;
  logic              rd_ok;
  logic              pop_ok;
  logic              wr_take;
  logic              acc_we;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_err;
  logic              flag_z;
  logic              flag_n;
  logic              stack_err;

  assign wr_ok  = ({1'b0, bus.wr_sel} < NUM_ACC_V);
  assign rd_ok  = ({1'b0, bus.rd_sel} < NUM_ACC_V);
  assign rd_val = rd_ok ? acc[bus.rd_sel] : '0;

  // A pop that is not paired with a push owns the write port, legal or not.
  assign pop_ok  = bus.pop & ~bus.push & ~stk_empty;
  assign wr_take = bus.wr_en & ~(bus.pop & ~bus.push);
  assign acc_we  = (pop_ok | wr_take) & wr_ok;

  always_comb begin
    src_data = '0;
    unique case (bus.src_sel)
      ACC_SRC_ALU: src_data = bus.data_alu;
      ACC_SRC_MEM: src_data = bus.data_mem;
      ACC_SRC_IMM: src_data = bus.data_imm;
      ACC_SRC_CLR: src_data = '0;
      default:     src_data = '0;
    endcase
  end

  assign wr_data = pop_ok ? stk_dout : src_data;

  // Flags track whatever value last landed in an accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc[i] <= '0;
      end
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (acc_we) begin
      acc[bus.wr_sel] <= wr_data;
      flag_z          <= (wr_data == '0);
      flag_n          <= wr_data[DATA_W-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_err <= 1'b0;
    end else if (stk_err) begin
      stack_err <= 1'b1;
    end else if (bus.err_clr) begin
      stack_err <= 1'b0;
    end
  end

  acc_stack #(
    .DATA_W      (DATA_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.push),
    .pop       (bus.pop),
    .din       (rd_val),
    .dout      (stk_dout),
    .full      (stk_full),
    .empty     (stk_empty),
    .err_pulse (stk_err)
  );

  assign bus.rd_data     = rd_val;
  assign bus.flag_z      = flag_z;
  assign bus.flag_n      = flag_n;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
  assign bus.stack_err   = stack_err;

endmodule

// File: tb/tb_acc_bank.sv
// Directed scoreboard bench for acc_bank: an 8-bit/4-acc/depth-4 instance and a 16-bit/3-acc/depth-1 instance.
module tb_acc_bank;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] data;
    logic        z;
    logic        n;
    logic        full;
    logic        empty;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  acc_bank_if #(.DATA_W(8),  .NUM_ACC(4)) bus8 ();
  acc_bank_if #(.DATA_W(16), .NUM_ACC(3)) bus16 ();

  acc_bank #(.DATA_W(8), .NUM_ACC(4), .STACK_DEPTH(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  acc_bank #(.DATA_W(16), .NUM_ACC(3), .STACK_DEPTH(1)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic cmp(input string tag, input string field, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
    end
  endtask

  task automatic idleBus();
    bus8.wr_en    = 1'b0;
    bus8.push     = 1'b0;
    bus8.pop      = 1'b0;
    bus8.err_clr  = 1'b0;
    bus16.wr_en   = 1'b0;
    bus16.push    = 1'b0;
    bus16.pop     = 1'b0;
    bus16.err_clr = 1'b0;
  endtask

  task automatic checkOutput(input int dut);
    exp_t        e;
    logic [15:0] d;
    logic        z, n, f, em, er;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard observed=empty required=entry");
      return;
    end
    e = sbq.pop_front();
    if (dut == 0) begin
      d = {8'h00, bus8.rd_data};
      z = bus8.flag_z; n = bus8.flag_n; f = bus8.stack_full;
      em = bus8.stack_empty; er = bus8.stack_err;
    end else begin
      d = bus16.rd_data;
      z = bus16.flag_z; n = bus16.flag_n; f = bus16.stack_full;
      em = bus16.stack_empty; er = bus16.stack_err;
    end
    cmp(e.tag, "rd_data",     d,           e.data);
    cmp(e.tag, "flag_z",      {15'b0, z},  {15'b0, e.z});
    cmp(e.tag, "flag_n",      {15'b0, n},  {15'b0, e.n});
    cmp(e.tag, "stack_full",  {15'b0, f},  {15'b0, e.full});
    cmp(e.tag, "stack_empty", {15'b0, em}, {15'b0, e.empty});
    cmp(e.tag, "stack_err",   {15'b0, er}, {15'b0, e.err});
  endtask

  // Drives one cycle of control, queues the expected post-edge state, then checks it.
  task automatic applyStimulus(
    input int dut, input string tag,
    input logic we, input logic [1:0] ws, input acc_src_e src, input logic [15:0] val,
    input logic [1:0] rs, input logic ps, input logic pp, input logic ec,
    input logic [15:0] ed, input logic ez, input logic en,
    input logic ef, input logic eem, input logic eer
  );
    logic [15:0] junk;
    logic [15:0] alu, mem, imm;
    junk = ~val ^ 16'h0F0F;
    alu  = (src == ACC_SRC_ALU) ? val : junk;
    mem  = (src == ACC_SRC_MEM) ? val : junk;
    imm  = (src == ACC_SRC_IMM) ? val : junk;
    if (dut == 0) begin
      bus8.wr_en = we; bus8.wr_sel = ws; bus8.src_sel = src;
      bus8.data_alu = alu[7:0]; bus8.data_mem = mem[7:0]; bus8.data_imm = imm[7:0];
      bus8.rd_sel = rs; bus8.push = ps; bus8.pop = pp; bus8.err_clr = ec;
    end else begin
      bus16.wr_en = we; bus16.wr_sel = ws; bus16.src_sel = src;
      bus16.data_alu = alu; bus16.data_mem = mem; bus16.data_imm = imm;
      bus16.rd_sel = rs; bus16.push = ps; bus16.pop = pp; bus16.err_clr = ec;
    end
    sbq.push_back('{tag, ed, ez, en, ef, eem, eer});
    @(posedge clk);
    #1;
    idleBus();
    checkOutput(dut);
  endtask

  initial begin
    rst = 1'b1;
    idleBus();
    bus8.wr_sel = '0;   bus8.rd_sel = '0;   bus8.src_sel = ACC_SRC_ALU;
    bus8.data_alu = '0; bus8.data_mem = '0; bus8.data_imm = '0;
    bus16.wr_sel = '0;  bus16.rd_sel = '0;  bus16.src_sel = ACC_SRC_ALU;
    bus16.data_alu = '0; bus16.data_mem = '0; bus16.data_imm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //           dut tag           we ws src          val      rs ps pp ec  data     z n f e r
    applyStimulus(0, "junk_wr",    1, 0, ACC_SRC_ALU, 16'hFF,  0, 0, 0, 0, 16'hFF,  0,1,0,1,0);
    applyStimulus(0, "junk_push",  0, 0, ACC_SRC_ALU, 16'h00,  0, 1, 0, 0, 16'hFF,  0,1,0,0,0);
    applyStimulus(0, "junk_err",   0, 0, ACC_SRC_ALU, 16'h00,  0, 1, 1, 0, 16'hFF,  0,1,0,0,1);

    // Reset arrives mid-cycle and must clear outputs without waiting for a clock.
    #4 rst = 1'b1;
    sbq.push_back('{"rst_async", 16'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    #1 checkOutput(0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(0, "rst_read0",  0, 0, ACC_SRC_ALU, 16'h00,  0, 0, 0, 0, 16'h00,  0,0,0,1,0);

    applyStimulus(0, "src_alu",    1, 2, ACC_SRC_ALU, 16'h5A,  2, 0, 0, 0, 16'h5A,  0,0,0,1,0);
    applyStimulus(0, "src_mem",    1, 2, ACC_SRC_MEM, 16'h80,  2, 0, 0, 0, 16'h80,  0,1,0,1,0);
    applyStimulus(0, "flag_hold",  0, 0, ACC_SRC_ALU, 16'h00,  0, 0, 0, 0, 16'h00,  0,1,0,1,0);
    applyStimulus(0, "src_imm",    1, 2, ACC_SRC_IMM, 16'h00,  2, 0, 0, 0, 16'h00,  1,0,0,1,0);
    applyStimulus(0, "src_imm2",   1, 2, ACC_SRC_IMM, 16'h77,  2, 0, 0, 0, 16'h77,  0,0,0,1,0);
    applyStimulus(0, "src_clr",    1, 2, ACC_SRC_CLR, 16'hA5,  2, 0, 0, 0, 16'h00,  1,0,0,1,0);

    applyStimulus(0, "sr_acc1",    1, 1, ACC_SRC_ALU, 16'h33,  1, 0, 0, 0, 16'h33,  0,0,0,1,0);
    applyStimulus(0, "sr_push_wr", 1, 1, ACC_SRC_ALU, 16'h44,  1, 1, 0, 0, 16'h44,  0,0,0,0,0);
    applyStimulus(0, "sr_pop",     1, 3, ACC_SRC_ALU, 16'hEE,  3, 0, 1, 0, 16'h33,  0,0,0,1,0);
    applyStimulus(0, "sr_rd1",     0, 0, ACC_SRC_ALU, 16'h00,  1, 0, 0, 0, 16'h44,  0,0,0,1,0);

    applyStimulus(0, "f_w0",       1, 0, ACC_SRC_ALU, 16'h91,  0, 0, 0, 0, 16'h91,  0,1,0,1,0);
    applyStimulus(0, "f_w2",       1, 2, ACC_SRC_IMM, 16'h22,  2, 0, 0, 0, 16'h22,  0,0,0,1,0);
    applyStimulus(0, "f_push1",    0, 0, ACC_SRC_ALU, 16'h00,  0, 1, 0, 0, 16'h91,  0,0,0,0,0);
    applyStimulus(0, "f_push2",    0, 0, ACC_SRC_ALU, 16'h00,  1, 1, 0, 0, 16'h44,  0,0,0,0,0);
    applyStimulus(0, "f_push3",    0, 0, ACC_SRC_ALU, 16'h00,  2, 1, 0, 0, 16'h22,  0,0,0,0,0);
    applyStimulus(0, "f_push4",    0, 0, ACC_SRC_ALU, 16'h00,  3, 1, 0, 0, 16'h33,  0,0,1,0,0);
    applyStimulus(0, "f_push5",    0, 0, ACC_SRC_ALU, 16'h00,  0, 1, 0, 0, 16'h91,  0,0,1,0,1);
    applyStimulus(0, "f_pop1",     0, 2, ACC_SRC_ALU, 16'h00,  2, 0, 1, 0, 16'h33,  0,0,0,0,1);
    applyStimulus(0, "f_pop2",     0, 2, ACC_SRC_ALU, 16'h00,  2, 0, 1, 0, 16'h22,  0,0,0,0,1);
    applyStimulus(0, "f_pop3",     0, 2, ACC_SRC_ALU, 16'h00,  2, 0, 1, 0, 16'h44,  0,0,0,0,1);
    applyStimulus(0, "f_pop4",     0, 2, ACC_SRC_ALU, 16'h00,  2, 0, 1, 0, 16'h91,  0,1,0,1,1);

    applyStimulus(0, "e_clr",      0, 0, ACC_SRC_ALU, 16'h00,  2, 0, 0, 1, 16'h91,  0,1,0,1,0);
    applyStimulus(0, "e_popempty", 1, 2, ACC_SRC_ALU, 16'h55,  2, 0, 1, 0, 16'h91,  0,1,0,1,1);
    applyStimulus(0, "e_clr2",     0, 0, ACC_SRC_ALU, 16'h00,  2, 0, 0, 1, 16'h91,  0,1,0,1,0);
    applyStimulus(0, "e_push",     0, 0, ACC_SRC_ALU, 16'h00,  0, 1, 0, 0, 16'h91,  0,1,0,0,0);
    applyStimulus(0, "e_pushpop",  1, 1, ACC_SRC_IMM, 16'h00,  1, 1, 1, 0, 16'h00,  1,0,0,0,1);
    applyStimulus(0, "e_clr_err",  0, 0, ACC_SRC_ALU, 16'h00,  1, 1, 1, 1, 16'h00,  1,0,0,0,1);
    applyStimulus(0, "e_pop_fin",  0, 3, ACC_SRC_ALU, 16'h00,  3, 0, 1, 0, 16'h91,  0,1,0,1,1);
    applyStimulus(0, "e_clr3",     0, 0, ACC_SRC_ALU, 16'h00,  3, 0, 0, 1, 16'h91,  0,1,0,1,0);

    applyStimulus(1, "p_w3",       1, 3, ACC_SRC_ALU, 16'hBEEF, 3, 0, 0, 0, 16'h0000, 0,0,0,1,0);
    applyStimulus(1, "p_w0",       1, 0, ACC_SRC_MEM, 16'h8001, 0, 0, 0, 0, 16'h8001, 0,1,0,1,0);
    applyStimulus(1, "p_push",     0, 0, ACC_SRC_ALU, 16'h0000, 0, 1, 0, 0, 16'h8001, 0,1,1,0,0);
    applyStimulus(1, "p_push2",    0, 0, ACC_SRC_ALU, 16'h0000, 0, 1, 0, 0, 16'h8001, 0,1,1,0,1);
    applyStimulus(1, "p_pop",      0, 2, ACC_SRC_ALU, 16'h0000, 2, 0, 1, 0, 16'h8001, 0,1,0,1,1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
